// File: rtl/meio_subtrator.sv
// meio_subtrator: WIDTH-lane half subtractor (a-b -> diff,borrow) with registered copy, out_valid and saturating borrow counter
module meio_subtrator #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] borrow_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_cnt
);
  logic [WIDTH-1:0] diff_d, borrow_d;
  logic             out_valid_d;
  logic [CNT_W-1:0] borrow_cnt_d;
  assign diff   = a ^ b;
  assign borrow = ~a & b;
  always_comb begin
    diff_d       = in_valid ? diff : diff_q;
    borrow_d     = in_valid ? borrow : borrow_q;
    out_valid_d  = in_valid;
    borrow_cnt_d = (in_valid && |borrow && !(&borrow_cnt)) ? borrow_cnt + CNT_W'(1) : borrow_cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q     <= '0;
      borrow_q   <= '0;
      out_valid  <= 1'b0;
      borrow_cnt <= '0;
    end else begin
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      out_valid  <= out_valid_d;
      borrow_cnt <= borrow_cnt_d;
    end
  end
endmodule

// File: tb/tb_meio_subtrator.sv
// tb_meio_subtrator: scoreboard bench for meio_subtrator (WIDTH=1/CNT_W=8 and WIDTH=4/CNT_W=2)
module tb_meio_subtrator;
  logic clk = 1'b0, clk_en = 1'b0, rst_n = 1'b0;
  logic a0 = 1'b0, b0 = 1'b0, iv0 = 1'b0;
  logic d0, br0, dq0, bq0, ov0;
  logic [7:0] cnt0;
  logic [3:0] a1 = '0, b1 = '0;
  logic iv1 = 1'b0;
  logic [3:0] d1, br1, dq1, bq1;
  logic ov1;
  logic [1:0] cnt1;
  int n_vec = 0, n_bad = 0;
  logic [1:0] q0[$];
  logic [7:0] q1[$];
  always #5 if (clk_en) clk = ~clk;
  meio_subtrator u0 (.clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .in_valid(iv0),
    .diff(d0), .borrow(br0), .diff_q(dq0), .borrow_q(bq0), .out_valid(ov0), .borrow_cnt(cnt0));
  meio_subtrator #(.WIDTH(4), .CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
    .diff(d1), .borrow(br1), .diff_q(dq1), .borrow_q(bq1), .out_valid(ov1), .borrow_cnt(cnt1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step0(input logic a, input logic b, input logic v, input logic ed, input logic eb);
    a0 = a; b0 = b; iv0 = v;
    if (v) q0.push_back({ed, eb});
    @(posedge clk); #2;
  endtask
  task automatic step1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ed, input logic [3:0] eb);
    a1 = a; b1 = b; iv1 = 1'b1;
    q1.push_back({ed, eb});
    @(posedge clk); #2;
  endtask
  always @(negedge clk) begin
    if (rst_n && ov0) begin
      if (q0.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb0_unexpected: got out_valid=1 want no pending result");
      end else begin
        logic [1:0] e;
        e = q0.pop_front();
        chk("sb0_diff_borrow_q", {dq0, bq0}, e);
      end
    end
    if (rst_n && ov1) begin
      if (q1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb1_unexpected: got out_valid=1 want no pending result");
      end else begin
        logic [7:0] e;
        e = q1.pop_front();
        chk("sb1_diff_borrow_q", {dq1, bq1}, e);
      end
    end
  end
  initial begin
    logic [3:0] tab_d, tab_b;
    logic [3:0] va[4], vb[4], vd[4], vbr[4];
    tab_d = 4'b0110;
    tab_b = 4'b0010;
    va = '{4'b0101, 4'b1111, 4'b0000, 4'b1010};
    vb = '{4'b0011, 4'b0000, 4'b1111, 4'b1100};
    vd = '{4'b0110, 4'b1111, 4'b1111, 4'b0110};
    vbr = '{4'b0010, 4'b0000, 4'b1111, 4'b0100};
    #1;
    chk("rst_diff_q", dq0, 0);
    chk("rst_borrow_q", bq0, 0);
    chk("rst_out_valid", ov0, 0);
    chk("rst_cnt", cnt0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        {a0, b0} = 2'(i);
        #5;
        chk("comb_diff", d0, tab_d[i]);
        chk("comb_borrow", br0, tab_b[i]);
      end
      rst_n = 1'b1;
    end
    a0 = 0; b0 = 0;
    clk_en = 1'b1;
    @(posedge clk); #2;
    step0(0, 1, 1, 1, 1);
    chk("reg_diff_q", dq0, 1);
    chk("reg_borrow_q", bq0, 1);
    chk("reg_out_valid", ov0, 1);
    step0(0, 0, 0, 0, 0);
    chk("idle_out_valid", ov0, 0);
    chk("idle_diff_hold", dq0, 1);
    chk("idle_borrow_hold", bq0, 1);
    chk("idle_cnt", cnt0, 1);
    step0(0, 1, 1, 1, 1);
    step0(1, 0, 1, 1, 0);
    chk("cnt_no_borrow", cnt0, 2);
    step0(1, 1, 1, 0, 0);
    step0(0, 1, 1, 1, 1);
    chk("cnt_three", cnt0, 3);
    chk("pre_rst_diff_q", dq0, 1);
    #4;
    rst_n = 1'b0; iv0 = 1'b0;
    #1;
    chk("async_diff_q", dq0, 0);
    chk("async_borrow_q", bq0, 0);
    chk("async_out_valid", ov0, 0);
    chk("async_cnt", cnt0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 5; i++) begin
      step1(4'b0000, 4'b0001, 4'b0001, 4'b0001);
      chk("sat_cnt", cnt1, (i < 3) ? i + 1 : 3);
    end
    step1(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    chk("sat_hold_no_borrow", cnt1, 3);
    for (int i = 0; i < 4; i++) begin
      a1 = va[i]; b1 = vb[i]; iv1 = 1'b0;
      #1;
      chk("lane_diff", d1, vd[i]);
      chk("lane_borrow", br1, vbr[i]);
      @(posedge clk); #2;
      step1(va[i], vb[i], vd[i], vbr[i]);
    end
    iv1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/meio_subtrator.md
Name: meio_subtrator

Overview:
- Half subtractor (minuend a, subtrahend b → difference, borrow) for the digital-circuits training datapath.
- Combinational outputs give the classic zero-latency half-subtractor function.
- A registered copy, a valid flag and a borrow-event counter let the block sit in a clocked pipeline and be monitored.
- Vector form is a bank of independent half subtractors: no borrow chaining between bits.

Parameters:
- WIDTH, 1, number of independent half-subtractor lanes (≥1).
- CNT_W, 8, width of the saturating borrow-event counter (≥1).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  minuend bits.
- b  input  WIDTH  subtrahend bits.
- in_valid  input  1  qualifies a/b for the registered path and the counter.
- diff  output  WIDTH  combinational difference.
- borrow  output  WIDTH  combinational borrow.
- diff_q  output  WIDTH  registered difference.
- borrow_q  output  WIDTH  registered borrow.
- out_valid  output  1  diff_q/borrow_q hold a valid result.
- borrow_cnt  output  CNT_W  saturating count of accepted samples with any borrow bit set.

Behaviour:
- Combinational path, per lane i:
  - diff[i] = a[i] XOR b[i]
  - borrow[i] = (NOT a[i]) AND b[i]
  - No clock dependence; settles within propagation delay.
  - Independent of rst_n, in_valid and clk.
- Truth table, per lane (a b → diff borrow): 00→0 0; 01→1 1; 10→1 0; 11→0 0.
- Reset: rst_n low asynchronously clears diff_q, borrow_q, out_valid and borrow_cnt to 0 immediately, whether mid-operation or not. Release is sampled on the next rising clk.
- Registered path, on each rising clk with rst_n high:
  - If in_valid = 1: diff_q ← diff, borrow_q ← borrow, out_valid ← 1.
  - If in_valid = 0: diff_q and borrow_q hold their values; out_valid ← 0.
  - Latency is 1 cycle from accepted input to out_valid.
- Counter, on each rising clk with rst_n high:
  - If in_valid = 1, borrow is nonzero (any lane) and borrow_cnt < 2^CNT_W−1: increment by 1.
  - At the all-ones value it saturates and holds; no wrap-around.
- X/Z on inputs: no special handling required. Outputs follow the gate equations.

Test Plan:
- Exhaustive combinational check, WIDTH=1: drive {a,b} = 00,01,10,11, wait 5 ns each → (diff,borrow) = (0,0),(1,1),(1,0),(0,0), compared with !== against a^b and ~a&b. This must hold with clk idle and rst_n low as well as high.
- Registered path: hold rst_n=1, in_valid=1, drive a=0, b=1, then one rising edge → diff_q=1, borrow_q=1, out_valid=1. Next cycle with in_valid=0 → out_valid=0 and diff_q/borrow_q unchanged.
- Asynchronous reset mid-operation: after loading diff_q=1 and borrow_cnt=3, pull rst_n low between clock edges → diff_q, borrow_q, out_valid and borrow_cnt read 0 before the next edge.
- Counter saturation: CNT_W=2, in_valid=1, a=0, b=1 for 5 cycles → borrow_cnt goes 1,2,3,3,3. Then a=1, b=0 → stays 3.
- Vector lanes: WIDTH=4, a=4'b0101, b=4'b0011 → diff=4'b0110 and borrow=4'b0010, with no inter-lane borrow propagation.
